// File: rtl/iir_bw_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_bw_filter_if : sample/coef/result handshake bundle              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface iir_bw_filter_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          clr;
  logic          coef_we;
  logic [CW-1:0] coef_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] y_out;
  logic          out_sat;

  modport master (
    output clr, coef_we, coef_in, in_valid, x_in, out_ready,
    input  in_ready, out_valid, y_out, out_sat
  );

  modport slave (
    input  clr, coef_we, coef_in, in_valid, x_in, out_ready,
    output in_ready, out_valid, y_out, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/iir_bw_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_bw_filter : first-order IIR, serial Baugh-Wooley multiplier     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module iir_bw_filter #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int FRAC = 6,
  parameter int SAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  iir_bw_filter_if.slave   bus_io
);

  localparam int W    = DW + CW;
  localparam int CNTW = $clog2(CW);
  // General Baugh-Wooley correction; equals bits DW and W-1 when DW == CW.
  localparam logic [W-1:0] c_bw_k = (W'(1) << (DW - 1)) + (W'(1) << (CW - 1))
                                  + (W'(1) << (W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   coef_q, coef_d;
  logic [CW-1:0]   wcoef_q, wcoef_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   y_prev_q, y_prev_d;
  logic [DW-1:0]   y_out_q, y_out_d;
  logic            sat_q, sat_d;
  logic [W-1:0]    prod_q, prod_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic               w_last;
  logic [DW-1:0]      w_pp;
  logic [DW-1:0]      w_row;
  logic [W-1:0]       w_row_sh;
  logic signed [W-1:0] w_ps;
  logic signed [W:0]  w_sum;
  logic [DW-1:0]      w_res;
  logic               w_clip;

  assign w_last   = (cnt_q == CNTW'(CW - 1));
  assign w_pp     = mcand_q & {DW{wcoef_q[cnt_q]}};
  // Ordinary rows invert the sign-bit term; the coefficient sign row inverts the rest.
  assign w_row    = w_pp ^ (w_last ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}});
  assign w_row_sh = {{CW{1'b0}}, w_row} << cnt_q;

  assign w_ps  = $signed(prod_q) >>> FRAC;
  assign w_sum = $signed({{(W+1-DW){x_q[DW-1]}}, x_q}) + $signed({w_ps[W-1], w_ps});

  generate
    if (SAT != 0) begin : g_sat
      localparam logic signed [W:0] c_smax = $signed({{(W-DW+2){1'b0}}, {(DW-1){1'b1}}});
      localparam logic signed [W:0] c_smin = ~c_smax;
      assign w_clip = (w_sum > c_smax) || (w_sum < c_smin);
      assign w_res  = (w_sum > c_smax) ? c_smax[DW-1:0] :
                      (w_sum < c_smin) ? c_smin[DW-1:0] : w_sum[DW-1:0];
    end else begin : g_wrap
      assign w_clip = 1'b0;
      assign w_res  = w_sum[DW-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    coef_d   = coef_q;
    wcoef_d  = wcoef_q;
    x_d      = x_q;
    mcand_d  = mcand_q;
    y_prev_d = y_prev_q;
    y_out_d  = y_out_q;
    sat_d    = sat_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    if (bus_io.coef_we) coef_d = bus_io.coef_in;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          x_d     = bus_io.x_in;
          wcoef_d = coef_q;
          mcand_d = y_prev_q;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d = prod_q + w_row_sh + ((cnt_q == '0) ? c_bw_k : '0);
        cnt_d  = cnt_q + 1'b1;
        if (w_last) state_d = ACC;
      end
      ACC: begin
        y_out_d  = w_res;
        y_prev_d = w_res;
        sat_d    = w_clip;
        state_d  = OUT;
      end
      OUT: begin
        if (bus_io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear drops any in-flight sample but leaves the coefficient alone.
    if (bus_io.clr) begin
      state_d  = IDLE;
      y_prev_d = '0;
      y_out_d  = '0;
      sat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      coef_q   <= '0;
      wcoef_q  <= '0;
      x_q      <= '0;
      mcand_q  <= '0;
      y_prev_q <= '0;
      y_out_q  <= '0;
      sat_q    <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      coef_q   <= coef_d;
      wcoef_q  <= wcoef_d;
      x_q      <= x_d;
      mcand_q  <= mcand_d;
      y_prev_q <= y_prev_d;
      y_out_q  <= y_out_d;
      sat_q    <= sat_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_io.in_ready  = (state_q == IDLE) && !rst;
  assign bus_io.out_valid = (state_q == OUT);
  assign bus_io.y_out     = y_out_q;
  assign bus_io.out_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_bw_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_iir_bw_filter : saturating and wrapping instances vs. model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_iir_bw_filter;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int FRAC = 6;

  logic          clk = 1'b0;
  logic          rst, clr, coef_we, in_valid, out_ready;
  logic [CW-1:0] coef_in;
  logic [DW-1:0] x_in;

  int n_chk = 0;
  int n_err = 0;
  int coef_m, yp_s, yp_w;

  always #5 clk = ~clk;

  iir_bw_filter_if #(.DW(DW), .CW(CW)) if_s ();
  iir_bw_filter_if #(.DW(DW), .CW(CW)) if_w ();

  assign if_s.clr = clr;       assign if_w.clr = clr;
  assign if_s.coef_we = coef_we; assign if_w.coef_we = coef_we;
  assign if_s.coef_in = coef_in; assign if_w.coef_in = coef_in;
  assign if_s.in_valid = in_valid; assign if_w.in_valid = in_valid;
  assign if_s.x_in = x_in;     assign if_w.x_in = x_in;
  assign if_s.out_ready = out_ready; assign if_w.out_ready = out_ready;

  iir_bw_filter #(.DW(DW), .CW(CW), .FRAC(FRAC), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .bus_io(if_s)
  );
  iir_bw_filter #(.DW(DW), .CW(CW), .FRAC(FRAC), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .bus_io(if_w)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // y = x + floor(y_prev * coef / 2^FRAC), then clip or wrap to DW bits.
  function automatic int model(input int x, input int yp, input int a,
                               input bit sat, output bit clip);
    int lim, s;
    lim  = 2 ** (DW - 1);
    s    = x + ((yp * a) >>> FRAC);
    clip = 1'b0;
    if (sat) begin
      if (s > lim - 1) begin s = lim - 1; clip = 1'b1; end
      else if (s < -lim) begin s = -lim; clip = 1'b1; end
    end else begin
      s = ((s % (2 ** DW)) + (2 ** DW)) % (2 ** DW);
      if (s >= lim) s -= 2 ** DW;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int c);
    coef_we = 1'b1;
    coef_in = CW'(c);
    tick();
    coef_we = 1'b0;
    coef_m  = c;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr  = 1'b0;
    yp_s = 0;
    yp_w = 0;
  endtask

  task automatic do_sample(input int x, input int hold, input bit wr_mid,
                           input int cmid, input bit clr_out);
    int lat, es, ew;
    bit cs, cw;
    es = model(x, yp_s, coef_m, 1'b1, cs);
    ew = model(x, yp_w, coef_m, 1'b0, cw);
    check("in_ready_idle", int'(if_s.in_ready), 1);
    x_in     = DW'(x);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!if_s.out_valid && lat < 40) begin
      coef_we = wr_mid && (lat == 3);
      coef_in = CW'(cmid);
      tick();
      lat++;
    end
    coef_we = 1'b0;
    if (wr_mid) coef_m = cmid;
    check("latency", lat, CW + 2);
    check("y_sat", $signed(if_s.y_out), es);
    check("flag_sat", int'(if_s.out_sat), int'(cs));
    check("y_wrap", $signed(if_w.y_out), ew);
    check("flag_wrap", int'(if_w.out_sat), int'(cw));
    yp_s = es;
    yp_w = ew;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", int'(if_s.out_valid), 1);
      check("hold_y", $signed(if_s.y_out), es);
      check("hold_in_ready", int'(if_s.in_ready), 0);
    end
    if (clr_out) begin
      pulse_clr();
      check("clr_valid", int'(if_s.out_valid), 0);
      check("clr_y", $signed(if_s.y_out), 0);
      check("clr_flag", int'(if_s.out_sat), 0);
    end else begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_valid", int'(if_s.out_valid), 0);
      check("post_y_kept", $signed(if_s.y_out), es);
      check("post_in_ready", int'(if_s.in_ready), 1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; clr = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    coef_in = '0; x_in = '0;
    coef_m = 0; yp_s = 0; yp_w = 0;
    repeat (3) tick();
    check("rst_in_ready", int'(if_s.in_ready), 0);
    check("rst_valid", int'(if_s.out_valid), 0);
    check("rst_y", $signed(if_s.y_out), 0);
    check("rst_flag", int'(if_s.out_sat), 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", int'(if_s.in_ready), 1);

    // impulse, a = 0.5
    wr_coef(32);
    do_sample(64, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) do_sample(0, 0, 1'b0, 0, 1'b0);

    // alternating decay, a = -0.5
    pulse_clr();
    wr_coef(-32);
    do_sample(64, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) do_sample(0, 0, 1'b0, 0, 1'b0);

    // saturation vs wrap, a = 1.0
    pulse_clr();
    wr_coef(64);
    do_sample(100, 0, 1'b0, 0, 1'b0);
    do_sample(100, 0, 1'b0, 0, 1'b0);

    // multiplier corner: -128 * -128
    pulse_clr();
    wr_coef(64);
    do_sample(-128, 0, 1'b0, 0, 1'b0);
    wr_coef(-128);
    do_sample(0, 0, 1'b0, 0, 1'b0);
    wr_coef(0);
    do_sample(5, 0, 1'b0, 0, 1'b0);

    // back-pressure with a coefficient write while multiplying
    wr_coef(32);
    do_sample(40, 5, 1'b1, -64, 1'b0);
    do_sample(20, 1, 1'b0, 0, 1'b0);

    // reset in the middle of the multiply
    x_in = DW'(77);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_in_ready", int'(if_s.in_ready), 0);
    rst = 1'b0;
    coef_m = 0; yp_s = 0; yp_w = 0;
    seen = 0;
    for (int i = 0; i < CW + 4; i++) begin
      tick();
      if (if_s.out_valid || if_w.out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    check("midrst_y", $signed(if_s.y_out), 0);
    do_sample(10, 0, 1'b0, 0, 1'b0);

    // clear while presenting a result
    wr_coef(32);
    do_sample(90, 2, 1'b0, 0, 1'b1);
    do_sample(0, 0, 1'b0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) wr_coef(int'($urandom_range(0, 255)) - 128);
      if ($urandom_range(0, 9) == 0) pulse_clr();
      do_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)),
                1'b0, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
